// File: rtl/tx_pkg.sv
// Shared TX datapath types and constants: word/counter widths, destination tag,
// drain state encoding and the entry format of the drain output buffer.
package tx_pkg;

    localparam int DATA_W    = 6;
    localparam int CNT_W     = 5;
    localparam int BUF_DEPTH = 2;

    typedef enum logic {
        DEST_D0 = 1'b0,
        DEST_D1 = 1'b1
    } dest_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } drain_state_t;

    typedef struct packed {
        dest_t             dest;
        logic [DATA_W-1:0] data;
    } obuf_entry_t;

endpackage

// File: rtl/d_drain_obuf.sv
// Two-entry FIFO buffer with combinational head, push/pop and occupancy.
// Ports: clk, rst_n (async low), clr (sync flush), push/push_data, pop,
//        empty, occ (0..2), head (oldest entry; meaningful when !empty).
module d_drain_obuf #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         empty,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   occ_q, occ_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (clr) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            occ_d    = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            // Push and pop together leave occupancy unchanged.
            occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign empty = (occ_q == 2'd0);
    assign occ   = occ_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/d_drain_arb.sv
// Drains destination FIFOs D0/D1 (round-robin, or strict D0 priority when
// D_DRAIN_ARB_PRIO_EN is defined) into one valid/ready stream tagged by source.
// Ports: clk, RESET_L (async low), init (sync clear), D*_empty/D*_data_out in,
//        POP_D* out, sink_ready in, valid_out/data_out/dest_out out,
//        cnt_d0/cnt_d1 delivered-word counters, idle.
module d_drain_arb
    import tx_pkg::*;
(
    input  logic              clk,
    input  logic              RESET_L,
    input  logic              init,
    input  logic              D0_empty,
    input  logic              D1_empty,
    input  logic [DATA_W-1:0] D0_data_out,
    input  logic [DATA_W-1:0] D1_data_out,
    output logic              POP_D0,
    output logic              POP_D1,
    input  logic              sink_ready,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              dest_out,
    output logic [CNT_W-1:0]  cnt_d0,
    output logic [CNT_W-1:0]  cnt_d1,
    output logic              idle
);

    drain_state_t     state_q, state_d;
    logic             in_flight_q, in_flight_d;
    dest_t            src_q, src_d;
    logic [CNT_W-1:0] cnt_d0_q, cnt_d0_d;
    logic [CNT_W-1:0] cnt_d1_q, cnt_d1_d;

    logic             buf_empty;
    logic [1:0]       buf_occ;
    obuf_entry_t      head;
    obuf_entry_t      push_entry;

    logic             xfer;
    logic [2:0]       slots_used;
    logic [1:0]       occ_next;
    logic             can_pop;
    logic             cand0, cand1;
    logic             pick1;
    logic             grant;
    logic             capture;

    assign valid_out = !buf_empty;
    assign xfer      = valid_out && sink_ready;
    assign cand0     = !D0_empty;
    assign cand1     = !D1_empty;

    // A word leaving this cycle frees its slot for a new pop.
    assign slots_used = {1'b0, buf_occ} + {2'b00, in_flight_q}
                      - {2'b00, xfer};
    assign can_pop    = (slots_used < 3'(BUF_DEPTH)) && !init
                      && (state_q != FLUSH);
    assign grant      = can_pop && (cand0 || cand1);

`ifdef D_DRAIN_ARB_PRIO_EN
    assign pick1 = !cand0;
`else
    logic rr_ptr_q, rr_ptr_d;

    assign pick1 = (cand0 && cand1) ? rr_ptr_q : cand1;

    // After any grant the pointer favours the side that was not served.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (init) begin
            rr_ptr_d = 1'b0;
        end else if (grant) begin
            rr_ptr_d = !pick1;
        end
    end

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign POP_D0 = grant && !pick1;
    assign POP_D1 = grant && pick1;

    // Popped data appears one cycle later; returning data is dropped on init.
    assign capture         = in_flight_q && !init;
    assign push_entry.dest = src_q;
    assign push_entry.data = (src_q == DEST_D1) ? D1_data_out : D0_data_out;

    d_drain_obuf #(
        .W($bits(obuf_entry_t))
    ) u_obuf (
        .clk      (clk),
        .rst_n    (RESET_L),
        .clr      (init),
        .push     (capture),
        .push_data(push_entry),
        .pop      (xfer),
        .empty    (buf_empty),
        .occ      (buf_occ),
        .head     (head)
    );

    assign occ_next = buf_occ + {1'b0, in_flight_q} - {1'b0, xfer};

    always_comb begin
        in_flight_d = grant;
        src_d       = src_q;
        cnt_d0_d    = cnt_d0_q;
        cnt_d1_d    = cnt_d1_q;
        state_d     = state_q;
        if (grant) begin
            src_d = pick1 ? DEST_D1 : DEST_D0;
        end
        if (init) begin
            in_flight_d = 1'b0;
            src_d       = DEST_D0;
            cnt_d0_d    = '0;
            cnt_d1_d    = '0;
            state_d     = FLUSH;
        end else begin
            if (xfer) begin
                if (head.dest == DEST_D1) begin
                    cnt_d1_d = cnt_d1_q + 1'b1;
                end else begin
                    cnt_d0_d = cnt_d0_q + 1'b1;
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (grant) state_d = ACTIVE;
                end
                ACTIVE: begin
                    if (!grant && occ_next == 2'd0) state_d = IDLE;
                end
                FLUSH: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q     <= IDLE;
            in_flight_q <= 1'b0;
            src_q       <= DEST_D0;
            cnt_d0_q    <= '0;
            cnt_d1_q    <= '0;
        end else begin
            state_q     <= state_d;
            in_flight_q <= in_flight_d;
            src_q       <= src_d;
            cnt_d0_q    <= cnt_d0_d;
            cnt_d1_q    <= cnt_d1_d;
        end
    end

    assign data_out = valid_out ? head.data : '0;
    assign dest_out = valid_out ? head.dest : 1'b0;
    assign cnt_d0   = cnt_d0_q;
    assign cnt_d1   = cnt_d1_q;
    assign idle     = !valid_out && !in_flight_q;

endmodule

// File: tb/tb_d_drain_arb.sv
// Scoreboard bench for d_drain_arb: FIFO models feed D0/D1, expected words
// are queued per destination at load time and popped on each transfer.
module tb_d_drain_arb;
    import tx_pkg::*;

    logic              clk = 1'b0;
    logic              RESET_L;
    logic              init;
    logic              D0_empty;
    logic              D1_empty;
    logic [DATA_W-1:0] D0_data_out;
    logic [DATA_W-1:0] D1_data_out;
    logic              POP_D0;
    logic              POP_D1;
    logic              sink_ready;
    logic              valid_out;
    logic [DATA_W-1:0] data_out;
    logic              dest_out;
    logic [CNT_W-1:0]  cnt_d0;
    logic [CNT_W-1:0]  cnt_d1;
    logic              idle;

    always #5 clk = ~clk;

    d_drain_arb dut (
        .clk        (clk),
        .RESET_L    (RESET_L),
        .init       (init),
        .D0_empty   (D0_empty),
        .D1_empty   (D1_empty),
        .D0_data_out(D0_data_out),
        .D1_data_out(D1_data_out),
        .POP_D0     (POP_D0),
        .POP_D1     (POP_D1),
        .sink_ready (sink_ready),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .dest_out   (dest_out),
        .cnt_d0     (cnt_d0),
        .cnt_d1     (cnt_d1),
        .idle       (idle)
    );

    logic [DATA_W-1:0] q0[$], q1[$];
    logic [DATA_W-1:0] e0[$], e1[$];
    bit                pop_log[$];
    int                n_chk = 0;
    int                n_err = 0;
    int                cyc = 0;
    int                n_pops = 0;
    int                n_xfer = 0;
    int                first_valid_cyc = -1;
    int                last_pop_cyc = -1;
    bit                pend0 = 0, pend1 = 0;
    bit                bp_track = 0;
    bit                flush_win = 0;
    logic [DATA_W-1:0] bp_expect = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Source FIFO model: data returned the cycle after a pop.
    always @(posedge clk) begin
        #1;
        if (pend0 && q0.size() > 0) D0_data_out = q0.pop_front();
        if (pend1 && q1.size() > 0) D1_data_out = q1.pop_front();
        pend0    = 1'b0;
        pend1    = 1'b0;
        D0_empty = (q0.size() == 0);
        D1_empty = (q1.size() == 0);
    end

    always @(negedge clk) begin
        if (RESET_L) begin
            if (init || flush_win)
                chk("init_pop", 32'({POP_D0, POP_D1}), 32'd0);
            if (POP_D0 || POP_D1) begin
                chk("pop_onehot", 32'({POP_D0, POP_D1}),
                    POP_D1 ? 32'd1 : 32'd2);
                chk("pop_nonempty", 32'(POP_D1 ? D1_empty : D0_empty), 32'd0);
                pend0 = POP_D0;
                pend1 = POP_D1;
                n_pops++;
                pop_log.push_back(POP_D1);
                last_pop_cyc = cyc;
            end
            if (valid_out && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bp_track && valid_out && !sink_ready)
                chk("bp_stable", 32'(data_out), 32'(bp_expect));
            if (valid_out && sink_ready) begin
                n_xfer++;
                if (dest_out) begin
                    if (e1.size() == 0) chk("sb_extra_d1", 32'(e1.size()), 32'd1);
                    else chk("sb_d1", 32'(data_out), 32'(e1.pop_front()));
                end else begin
                    if (e0.size() == 0) chk("sb_extra_d0", 32'(e0.size()), 32'd1);
                    else chk("sb_d0", 32'(data_out), 32'(e0.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input bit d, input logic [DATA_W-1:0] v);
        if (d) begin
            q1.push_back(v);
            e1.push_back(v);
            D1_empty = 1'b0;
        end else begin
            q0.push_back(v);
            e0.push_back(v);
            D0_empty = 1'b0;
        end
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_pop0"},  32'(POP_D0),    32'd0);
        chk({p, "_pop1"},  32'(POP_D1),    32'd0);
        chk({p, "_valid"}, 32'(valid_out), 32'd0);
        chk({p, "_data"},  32'(data_out),  32'd0);
        chk({p, "_dest"},  32'(dest_out),  32'd0);
        chk({p, "_cnt0"},  32'(cnt_d0),    32'd0);
        chk({p, "_cnt1"},  32'(cnt_d1),    32'd0);
        chk({p, "_idle"},  32'(idle),      32'd1);
    endtask

    task automatic clean_model();
        q0.delete();
        q1.delete();
        e0.delete();
        e1.delete();
        pend0    = 1'b0;
        pend1    = 1'b0;
        D0_empty = 1'b1;
        D1_empty = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 RESET_L = 1'b0;
        tick();
        clean_model();
        @(negedge clk);
        RESET_L = 1'b1;
        tick();
    endtask

    task automatic drain(input string tag, input int max);
        int k = 0;
        while (!(idle && q0.size() == 0 && q1.size() == 0 && !pend0 && !pend1)
               && k < max) begin
            tick();
            k++;
        end
        chk({tag, "_drain_to"}, 32'(k < max), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        RESET_L     = 1'b0;
        init        = 1'b0;
        sink_ready  = 1'b0;
        D0_empty    = 1'b1;
        D1_empty    = 1'b1;
        D0_data_out = '0;
        D1_data_out = '0;
        @(negedge clk);
        chk_reset_vals("por");
        RESET_L = 1'b1;
        tick();

        // Single word from D0.
        sink_ready = 1'b1;
        n_pops = 0;
        first_valid_cyc = -1;
        load(1'b0, 6'b001010);
        drain("t1", 50);
        chk("t1_npops", 32'(n_pops), 32'd1);
        chk("t1_latency", 32'(first_valid_cyc - last_pop_cyc), 32'd2);
        chk("t1_cnt_d0", 32'(cnt_d0), 32'd1);
        chk("t1_cnt_d1", 32'(cnt_d1), 32'd0);

        // Three words in each FIFO.
        do_reset();
        pop_log.delete();
        for (int i = 0; i < 3; i++) begin
            load(1'b0, 6'(8'h10 + i));
            load(1'b1, 6'(8'h20 + i));
        end
        drain("t2", 100);
        chk("t2_npops", 32'(pop_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < pop_log.size(); i++) begin
`ifdef D_DRAIN_ARB_PRIO_EN
            chk($sformatf("t2_order%0d", i), 32'(pop_log[i]), 32'(i >= 3));
`else
            chk($sformatf("t2_order%0d", i), 32'(pop_log[i]), 32'(i % 2));
`endif
        end
        chk("t2_cnt_d0", 32'(cnt_d0), 32'd3);
        chk("t2_cnt_d1", 32'(cnt_d1), 32'd3);

        // Backpressure with four words in D0.
        do_reset();
        sink_ready = 1'b0;
        n_pops = 0;
        bp_expect = 6'h30;
        for (int i = 0; i < 4; i++) load(1'b0, 6'(8'h30 + i));
        bp_track = 1'b1;
        repeat (8) tick();
        chk("bp_npops", 32'(n_pops), 32'd2);
        chk("bp_fifo_left", 32'(q0.size()), 32'd2);
        chk("bp_head", 32'(data_out), 32'h30);
        bp_track = 1'b0;
        sink_ready = 1'b1;
        n_xfer = 0;
        drain("bp", 100);
        chk("bp_nxfer", 32'(n_xfer), 32'd4);
        chk("bp_cnt_d0", 32'(cnt_d0), 32'd4);
        chk("bp_sb_left", 32'(e0.size()), 32'd0);

        // init pulse with two words buffered.
        do_reset();
        sink_ready = 1'b1;
        load(1'b0, 6'h05);
        drain("in0", 50);
        chk("in_cnt_pre", 32'(cnt_d0), 32'd1);
        sink_ready = 1'b0;
        load(1'b0, 6'h06);
        load(1'b0, 6'h07);
        repeat (6) tick();
        chk("in_valid_pre", 32'(valid_out), 32'd1);
        init = 1'b1;
        load(1'b1, 6'h2A);
        e0.delete();
        tick();
        chk("in_valid_drop", 32'(valid_out), 32'd0);
        chk("in_cnt_d0", 32'(cnt_d0), 32'd0);
        chk("in_cnt_d1", 32'(cnt_d1), 32'd0);
        tick();
        init = 1'b0;
        flush_win = 1'b1;
        tick();
        flush_win = 1'b0;
        @(negedge clk);
        chk("in_resume_pop", 32'(POP_D1), 32'd1);
        sink_ready = 1'b1;
        drain("in1", 50);
        chk("in_cnt_d1_post", 32'(cnt_d1), 32'd1);
        chk("in_cnt_d0_post", 32'(cnt_d0), 32'd0);

        // Counter wrap via 33 words from D1.
        do_reset();
        sink_ready = 1'b1;
        for (int i = 0; i < 33; i++) load(1'b1, 6'(i * 5 + 3));
        drain("wr", 400);
        chk("wr_cnt_d1", 32'(cnt_d1), 32'd1);
        chk("wr_cnt_d0", 32'(cnt_d0), 32'd0);

        // Reset with one word buffered and one in flight.
        sink_ready = 1'b0;
        load(1'b0, 6'h11);
        load(1'b0, 6'h12);
        tick();
        tick();
        chk("rm_pre_valid", 32'(valid_out), 32'd1);
        chk("rm_pre_idle", 32'(idle), 32'd0);
        #1 RESET_L = 1'b0;
        #1;
        chk_reset_vals("rm");
        tick();
        clean_model();
        @(negedge clk);
        RESET_L = 1'b1;
        repeat (4) tick();
        chk("rm_lost_valid", 32'(valid_out), 32'd0);
        chk("rm_lost_idle", 32'(idle), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
